// File: rtl/multi_phase_light_ctrl_pkg.sv
// Shared lamp codes, sequencer state encoding and a saturating step helper
// for the multi-phase traffic-light controller.
package multi_phase_light_ctrl_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_SET    = 2'd3
  } state_t;

  // Opposing requests cancel; otherwise step by one and clamp to [lo, hi].
  function automatic int unsigned sat_adj(input int unsigned val, input logic up,
                                          input logic dn, input int unsigned lo,
                                          input int unsigned hi);
    if (up && !dn) begin
      sat_adj = (val >= hi) ? hi : val + 32'd1;
    end else if (dn && !up) begin
      sat_adj = (val <= lo) ? lo : val - 32'd1;
    end else begin
      sat_adj = val;
    end
  endfunction

endpackage

// File: rtl/multi_phase_light_ctrl_tick_prescaler.sv
// One-second tick generator: counts 0..TICK_DIV-1 and pulses on the wrap.
// hold_i keeps the counter parked at zero.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hold_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-running divider, parked at zero while held
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (hold_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/multi_phase_light_ctrl.sv
// N-phase GREEN->YELLOW->ALL-RED sequencer with per-phase editable green times.
// Optional pedestrian walk service is built when macro PED_REQ_EN is defined.
module multi_phase_light_ctrl
  import multi_phase_light_ctrl_pkg::*;
#(
  parameter int N_PHASES  = 4,
  parameter int CNT_W     = 5,
  parameter int TICK_DIV  = 25_000_000,
  parameter int DEF_GREEN = 10,
  parameter int MIN_GREEN = 2,
  parameter int MAX_GREEN = 30,
  parameter int YEL_S     = 3,
  parameter int ALLRED_S  = 1,
  parameter int PED_MIN_S = 8,
  localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic                  btn_up_i,
  input  logic                  btn_down_i,
  input  logic                  btn_left_i,
  input  logic                  btn_right_i,
  input  logic [N_PHASES-1:0]   ped_req_i,
  output logic [PW-1:0]         phase_idx_o,
  output logic [2*N_PHASES-1:0] light_o,
  output logic [CNT_W-1:0]      sec_left_o,
  output logic [PW-1:0]         sel_idx_o,
  output logic [CNT_W-1:0]      sel_green_o,
  output logic [N_PHASES-1:0]   walk_o
);

  state_t                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d, sel_q, sel_d, nxt_phase_s;
  logic [CNT_W-1:0]        sec_q, sec_d, run_green_s;
  logic [CNT_W-1:0]        green_q [N_PHASES];
  logic [CNT_W-1:0]        green_d [N_PHASES];
  logic [2*N_PHASES-1:0]   light_q;
  logic                    tick_s, to_yellow_s, to_green_s, to_set_s;

  function automatic logic [2*N_PHASES-1:0] lamps(input state_t st, input logic [PW-1:0] ph);
    lamps = '0;
    for (int p = 0; p < N_PHASES; p++) begin
      if (PW'(p) == ph && st == ST_GREEN) begin
        lamps[2*p +: 2] = LAMP_GREEN;
      end else if (PW'(p) == ph && st == ST_YELLOW) begin
        lamps[2*p +: 2] = LAMP_YELLOW;
      end else begin
        lamps[2*p +: 2] = LAMP_RED;
      end
    end
  endfunction

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .hold_i (state_q == ST_SET),
    .tick_o (tick_s)
  );

  assign nxt_phase_s = (phase_q == PW'(N_PHASES - 1)) ? '0 : phase_q + PW'(1);

`ifdef PED_REQ_EN
  logic [N_PHASES-1:0] ped_q, ped_d, ped_set_s, walk_q, walk_d;

  // Latch requests except for the phase currently showing green; SET masks all.
  always_comb begin
    for (int p = 0; p < N_PHASES; p++) begin
      ped_set_s[p] = ped_q[p] | (ped_req_i[p] && (state_q != ST_SET) &&
                                 !(state_q == ST_GREEN && phase_q == PW'(p)));
    end
  end

  assign run_green_s = (ped_set_s[nxt_phase_s] && (green_q[nxt_phase_s] < CNT_W'(PED_MIN_S)))
                     ? CNT_W'(PED_MIN_S) : green_q[nxt_phase_s];

  // Walk lamp follows the served request from green entry until yellow
  always_comb begin
    ped_d  = ped_set_s;
    walk_d = walk_q;
    if (to_set_s) begin
      ped_d  = '0;
      walk_d = '0;
    end else if (to_yellow_s) begin
      ped_d[phase_q]  = 1'b0;
      walk_d[phase_q] = 1'b0;
    end else if (to_green_s) begin
      walk_d[nxt_phase_s] = ped_set_s[nxt_phase_s];
    end else begin
      walk_d = walk_q;
    end
  end

  // Pedestrian latch and walk registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ped_q  <= '0;
      walk_q <= '0;
    end else begin
      ped_q  <= ped_d;
      walk_q <= walk_d;
    end
  end

  assign walk_o = walk_q;
`else
  logic ped_unused_s;
  assign ped_unused_s = ^ped_req_i;
  assign run_green_s  = green_q[nxt_phase_s];
  assign walk_o       = '0;
`endif

  // Next-state logic for sequencing and set-mode editing
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sec_d       = sec_q;
    sel_d       = sel_q;
    green_d     = green_q;
    to_yellow_s = 1'b0;
    to_green_s  = 1'b0;
    to_set_s    = 1'b0;
    case (state_q)
      ST_GREEN, ST_YELLOW, ST_ALLRED: begin
        if (set_i) begin
          state_d  = ST_SET;
          to_set_s = 1'b1;
        end else if (tick_s && (sec_q > CNT_W'(1))) begin
          sec_d = sec_q - CNT_W'(1);
        end else if (tick_s) begin
          case (state_q)
            ST_GREEN: begin
              state_d     = ST_YELLOW;
              sec_d       = CNT_W'(YEL_S);
              to_yellow_s = 1'b1;
            end
            ST_YELLOW: begin
              state_d = ST_ALLRED;
              sec_d   = CNT_W'(ALLRED_S);
            end
            default: begin
              state_d    = ST_GREEN;
              phase_d    = nxt_phase_s;
              sec_d      = run_green_s;
              to_green_s = 1'b1;
            end
          endcase
        end else begin
          sec_d = sec_q;
        end
      end
      ST_SET: begin
        if (!set_i) begin
          state_d = ST_GREEN;
          phase_d = '0;
          sec_d   = green_q[0];
        end else begin
          if (btn_right_i && !btn_left_i) begin
            sel_d = (sel_q == PW'(N_PHASES - 1)) ? '0 : sel_q + PW'(1);
          end else if (btn_left_i && !btn_right_i) begin
            sel_d = (sel_q == '0) ? PW'(N_PHASES - 1) : sel_q - PW'(1);
          end else begin
            sel_d = sel_q;
          end
          green_d[sel_q] = CNT_W'(sat_adj(32'(green_q[sel_q]), btn_up_i, btn_down_i,
                                          32'(MIN_GREEN), 32'(MAX_GREEN)));
        end
      end
      default: begin
        state_d = ST_ALLRED;
        phase_d = '0;
        sec_d   = CNT_W'(ALLRED_S);
      end
    endcase
  end

  // Sequencer state, green-time file and registered lamp outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_GREEN;
      phase_q <= '0;
      sec_q   <= CNT_W'(DEF_GREEN);
      sel_q   <= '0;
      light_q <= lamps(ST_GREEN, '0);
      for (int p = 0; p < N_PHASES; p++) begin
        green_q[p] <= CNT_W'(DEF_GREEN);
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sec_q   <= sec_d;
      sel_q   <= sel_d;
      light_q <= lamps(state_d, phase_d);
      green_q <= green_d;
    end
  end

  assign phase_idx_o = phase_q;
  assign light_o     = light_q;
  assign sec_left_o  = sec_q;
  assign sel_idx_o   = sel_q;
  assign sel_green_o = green_q[sel_q];

endmodule

// File: tb/tb_multi_phase_light_ctrl.sv
// Directed, table-driven bench for multi_phase_light_ctrl (3 phases, 4-cycle tick).
module tb_multi_phase_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, set, up, dn, lt, rt;
  logic [2:0] ped_req;
  logic [1:0] phase_idx, sel_idx;
  logic [5:0] light;
  logic [4:0] sec_left, sel_green;
  logic [2:0] walk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int r0     = 0;

  typedef struct packed {
    logic [7:0] cyc;
    logic [1:0] ph;
    logic [5:0] light;
    logic [4:0] sec;
  } run_vec_t;

  typedef struct packed {
    logic       up, dn, lt, rt;
    logic [1:0] sel;
    logic [4:0] grn;
  } set_vec_t;

  run_vec_t rv [13];
  set_vec_t sv [17];

  always #5 clk = ~clk;

  multi_phase_light_ctrl #(
    .N_PHASES(3), .CNT_W(5), .TICK_DIV(4), .DEF_GREEN(3), .MIN_GREEN(2),
    .MAX_GREEN(6), .YEL_S(2), .ALLRED_S(1), .PED_MIN_S(5)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .set_i(set), .btn_up_i(up), .btn_down_i(dn),
    .btn_left_i(lt), .btn_right_i(rt), .ped_req_i(ped_req), .phase_idx_o(phase_idx),
    .light_o(light), .sec_left_o(sec_left), .sel_idx_o(sel_idx),
    .sel_green_o(sel_green), .walk_o(walk)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic btn(input logic u, input logic d, input logic l, input logic r);
    up = u; dn = d; lt = l; rt = r;
    adv(1);
    up = 1'b0; dn = 1'b0; lt = 1'b0; rt = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; set = 1'b0; up = 1'b0; dn = 1'b0; lt = 1'b0; rt = 1'b0; ped_req = 3'b000;

    rv[0]  = '{8'd0,  2'd0, 6'b000001, 5'd3};
    rv[1]  = '{8'd4,  2'd0, 6'b000001, 5'd2};
    rv[2]  = '{8'd11, 2'd0, 6'b000001, 5'd1};
    rv[3]  = '{8'd12, 2'd0, 6'b000010, 5'd2};
    rv[4]  = '{8'd19, 2'd0, 6'b000010, 5'd1};
    rv[5]  = '{8'd20, 2'd0, 6'b000000, 5'd1};
    rv[6]  = '{8'd24, 2'd1, 6'b000100, 5'd3};
    rv[7]  = '{8'd36, 2'd1, 6'b001000, 5'd2};
    rv[8]  = '{8'd44, 2'd1, 6'b000000, 5'd1};
    rv[9]  = '{8'd48, 2'd2, 6'b010000, 5'd3};
    rv[10] = '{8'd60, 2'd2, 6'b100000, 5'd2};
    rv[11] = '{8'd71, 2'd2, 6'b000000, 5'd1};
    rv[12] = '{8'd72, 2'd0, 6'b000001, 5'd3};

    sv[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 5'd3};
    sv[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd3};
    sv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 5'd4};
    sv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 5'd5};
    sv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 5'd6};
    sv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 5'd6};
    sv[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd5};
    sv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 5'd5};
    sv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd4};
    sv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd3};
    sv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd2};
    sv[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd2};
    sv[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 5'd3};
    sv[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd3};
    sv[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 5'd2};
    sv[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 5'd2};
    sv[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd3};

    // T1: reset
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    chk("rst_walk", walk, 3'b000);
    chk("rst_sel", sel_idx, 2'd0);
    chk("rst_sel_green", sel_green, 5'd3);

    // T2: free-running sequence through all phases and the wrap
    for (int i = 0; i < 13; i++) begin
      if (int'(rv[i].cyc) > cyc) adv(int'(rv[i].cyc) - cyc);
      chk("run_phase", phase_idx, rv[i].ph);
      chk("run_light", light, rv[i].light);
      chk("run_sec", sec_left, rv[i].sec);
      chk("run_walk", walk, 3'b000);
    end

    // T4: buttons outside set mode are ignored
    btn(1'b1, 1'b0, 1'b0, 1'b1);
    chk("run_btn_green", sel_green, 5'd3);
    chk("run_btn_sel", sel_idx, 2'd0);

    // T3/T4: set-mode editing table
    set = 1'b1;
    adv(1);
    chk("set_light", light, 6'b000000);
    adv(3);
    chk("set_frozen_light", light, 6'b000000);
    for (int i = 0; i < 17; i++) begin
      btn(sv[i].up, sv[i].dn, sv[i].lt, sv[i].rt);
      chk("set_sel", sel_idx, sv[i].sel);
      chk("set_green", sel_green, sv[i].grn);
    end
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sel_to_2", sel_idx, 2'd2);
    for (int i = 0; i < 10; i++) btn(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_max", sel_green, 5'd6);
    for (int i = 0; i < 10; i++) btn(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_min", sel_green, 5'd2);

    // Leave set mode: phase 0 restarts with a fresh tick counter
    set = 1'b0;
    adv(1);
    r0 = cyc;
    chk("exit_phase", phase_idx, 2'd0);
    chk("exit_light", light, 6'b000001);
    chk("exit_sec", sec_left, 5'd3);

    // T5: walk request for phase 1 (phase 0 request ignored while it is green)
    ped_req = 3'b011;
    adv(1);
    ped_req = 3'b000;
    adv(r0 + 11 - cyc);
    chk("exit_green_hold", light, 6'b000001);
    adv(1);
    chk("exit_yellow", light, 6'b000010);
    adv(r0 + 24 - cyc);
    chk("ped_green_light", light, 6'b000100);
`ifdef PED_REQ_EN
    chk("ped_walk_on", walk, 3'b010);
    chk("ped_sec", sec_left, 5'd5);
    adv(r0 + 43 - cyc);
    chk("ped_walk_hold", walk, 3'b010);
    chk("ped_green_hold", light, 6'b000100);
    adv(1);
`else
    chk("ped_walk_off", walk, 3'b000);
    chk("ped_sec", sec_left, 5'd3);
    adv(r0 + 35 - cyc);
    chk("ped_walk_hold", walk, 3'b000);
    chk("ped_green_hold", light, 6'b000100);
    adv(1);
`endif
    chk("ped_yellow_light", light, 6'b001000);
    chk("ped_walk_cleared", walk, 3'b000);

    // T6: reset mid-yellow of phase 1 beats simultaneous set and button
    adv(1);
    rst_n = 1'b0; set = 1'b1; up = 1'b1;
    adv(1);
    rst_n = 1'b1; set = 1'b0; up = 1'b0;
    chk("rst2_phase", phase_idx, 2'd0);
    chk("rst2_light", light, 6'b000001);
    chk("rst2_sec", sec_left, 5'd3);
    chk("rst2_walk", walk, 3'b000);
    chk("rst2_sel", sel_idx, 2'd0);
    set = 1'b1;
    adv(2);
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst2_green2", sel_green, 5'd3);
    set = 1'b0;
    adv(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
